// File: rtl/clock_reset_mgr.sv
`default_nettype none
// ============================================================================
// Module      : clock_reset_mgr
// Description : Central clock/reset manager. It models PLL lock and derives
//               the sys/usb/disk clocks from clk_ref. It releases the
//               per-domain active-low resets in sequence, synchronizes a
//               debug reset independently of rst_ext, and runs a sticky
//               watchdog that pulls the system back into reset.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_reset_mgr #(
    parameter int WATCHDOG_CYCLES = 25_000_000,
    parameter int LOCK_CYCLES     = 100,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk_ref,
    input  logic rst_ext,
    input  logic rst_debug_n,
    input  logic wdt_kick,
    output logic clk_sys,
    output logic clk_usb,
    output logic clk_disk,
    output logic rst_sys_n,
    output logic rst_usb_n,
    output logic rst_disk_n,
    output logic rst_dbg_sync_n,
    output logic pll_locked,
    output logic wdt_reset
);

    localparam int c_LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int c_WDT_W  = $clog2(2 * WATCHDOG_CYCLES);

    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST  = c_LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [c_WDT_W-1:0]  c_GRACE_LAST = c_WDT_W'(2 * WATCHDOG_CYCLES - 1);
    localparam logic [c_WDT_W-1:0]  c_ARMED_LAST = c_WDT_W'(WATCHDOG_CYCLES - 1);

    localparam logic [1:0] c_WDT_IDLE    = 2'd0;
    localparam logic [1:0] c_WDT_GRACE   = 2'd1;
    localparam logic [1:0] c_WDT_ARMED   = 2'd2;
    localparam logic [1:0] c_WDT_EXPIRED = 2'd3;

    // Declaration values give the power-up state, matching the rst_ext state
    // everywhere except the debug synchronizer, which powers up asserted.
    logic [c_LOCK_W-1:0]    r_lock_cnt   = '0;
    logic                   r_pll_locked = 1'b0;
    logic                   r_clk_usb    = 1'b0;
    logic [1:0]             r_disk_cnt   = 2'd0;
    logic [SYNC_STAGES-1:0] r_run_sync   = '0;
    logic                   r_rst_usb_n  = 1'b0;
    logic                   r_rst_disk_n = 1'b0;
    logic [SYNC_STAGES-1:0] r_dbg_sync   = '0;
    logic [1:0]             r_wdt_state  = c_WDT_IDLE;
    logic [c_WDT_W-1:0]     r_wdt_cnt    = '0;
    logic                   r_wdt_reset  = 1'b0;

    logic w_run;

    assign w_run          = r_pll_locked & ~r_wdt_reset;
    assign clk_sys        = clk_ref;
    assign clk_usb        = r_clk_usb;
    assign clk_disk       = r_disk_cnt[1];
    assign rst_sys_n      = r_run_sync[SYNC_STAGES-1];
    assign rst_usb_n      = r_rst_usb_n;
    assign rst_disk_n     = r_rst_disk_n;
    assign rst_dbg_sync_n = r_dbg_sync[SYNC_STAGES-1];
    assign pll_locked     = r_pll_locked;
    assign wdt_reset      = r_wdt_reset;

    // PLL model: count up from reset release, lock when the count reaches LOCK_CYCLES
    always_ff @(posedge clk_ref) begin
        if (rst_ext) begin
            r_lock_cnt   <= '0;
            r_pll_locked <= 1'b0;
        end else if (!r_pll_locked) begin
            r_lock_cnt <= r_lock_cnt + c_LOCK_W'(1);
            if (r_lock_cnt == c_LOCK_LAST) begin
                r_pll_locked <= 1'b1;
            end
        end
    end

    // Divided clocks run only once locked; held low otherwise
    always_ff @(posedge clk_ref) begin
        if (rst_ext || !r_pll_locked) begin
            r_clk_usb  <= 1'b0;
            r_disk_cnt <= 2'd0;
        end else begin
            r_clk_usb  <= ~r_clk_usb;
            r_disk_cnt <= r_disk_cnt + 2'd1;
        end
    end

    // Staggered domain reset release; any loss of run drops all three together
    always_ff @(posedge clk_ref) begin
        if (rst_ext || !w_run) begin
            r_run_sync   <= '0;
            r_rst_usb_n  <= 1'b0;
            r_rst_disk_n <= 1'b0;
        end else begin
            r_run_sync   <= {r_run_sync[SYNC_STAGES-2:0], 1'b1};
            r_rst_usb_n  <= r_run_sync[SYNC_STAGES-1];
            r_rst_disk_n <= r_rst_usb_n;
        end
    end

    // Debug reset synchronizer, deliberately untouched by rst_ext
    always_ff @(posedge clk_ref) begin
        r_dbg_sync <= {r_dbg_sync[SYNC_STAGES-2:0], rst_debug_n};
    end

    // Watchdog: long first window, then regular kick window; expiry is sticky
    always_ff @(posedge clk_ref) begin
        if (rst_ext) begin
            r_wdt_state <= c_WDT_IDLE;
            r_wdt_cnt   <= '0;
            r_wdt_reset <= 1'b0;
        end else begin
            case (r_wdt_state)
                c_WDT_IDLE: begin
                    r_wdt_cnt <= '0;
                    if (rst_sys_n) begin
                        r_wdt_state <= c_WDT_GRACE;
                    end
                end
                c_WDT_GRACE: begin
                    if (wdt_kick) begin
                        r_wdt_state <= c_WDT_ARMED;
                        r_wdt_cnt   <= '0;
                    end else if (r_wdt_cnt == c_GRACE_LAST) begin
                        r_wdt_state <= c_WDT_EXPIRED;
                        r_wdt_reset <= 1'b1;
                    end else begin
                        r_wdt_cnt <= r_wdt_cnt + c_WDT_W'(1);
                    end
                end
                c_WDT_ARMED: begin
                    if (wdt_kick) begin
                        r_wdt_cnt <= '0;
                    end else if (r_wdt_cnt == c_ARMED_LAST) begin
                        r_wdt_state <= c_WDT_EXPIRED;
                        r_wdt_reset <= 1'b1;
                    end else begin
                        r_wdt_cnt <= r_wdt_cnt + c_WDT_W'(1);
                    end
                end
                c_WDT_EXPIRED: begin
                    r_wdt_reset <= 1'b1;
                end
                default: begin
                    r_wdt_state <= c_WDT_IDLE;
                    r_wdt_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_reset_mgr.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_reset_mgr
// Description : Directed self-checking bench for clock_reset_mgr with
//               WATCHDOG_CYCLES=100, LOCK_CYCLES=100, SYNC_STAGES=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_reset_mgr;

    logic clk_ref = 1'b0;
    logic rst_ext;
    logic rst_debug_n;
    logic wdt_kick;
    logic clk_sys;
    logic clk_usb;
    logic clk_disk;
    logic rst_sys_n;
    logic rst_usb_n;
    logic rst_disk_n;
    logic rst_dbg_sync_n;
    logic pll_locked;
    logic wdt_reset;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_ref = ~clk_ref;

    clock_reset_mgr #(
        .WATCHDOG_CYCLES(100),
        .LOCK_CYCLES    (100),
        .SYNC_STAGES    (2)
    ) dut (
        .clk_ref       (clk_ref),
        .rst_ext       (rst_ext),
        .rst_debug_n   (rst_debug_n),
        .wdt_kick      (wdt_kick),
        .clk_sys       (clk_sys),
        .clk_usb       (clk_usb),
        .clk_disk      (clk_disk),
        .rst_sys_n     (rst_sys_n),
        .rst_usb_n     (rst_usb_n),
        .rst_disk_n    (rst_disk_n),
        .rst_dbg_sync_n(rst_dbg_sync_n),
        .pll_locked    (pll_locked),
        .wdt_reset     (wdt_reset)
    );

    // Advance n rising edges and land 1ns after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk_ref);
        #1;
    endtask

    task automatic test_reset();
        tick(2);
        n_cmp++;
        if ({rst_sys_n, rst_usb_n, rst_disk_n, pll_locked} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected %b", {rst_sys_n, rst_usb_n, rst_disk_n, pll_locked}, 4'b0000);
        end
        n_cmp++;
        if ({wdt_reset, clk_usb, clk_disk, rst_dbg_sync_n} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_misc: got %b expected %b", {wdt_reset, clk_usb, clk_disk, rst_dbg_sync_n}, 4'b0001);
        end
        tick(5);
    endtask

    task automatic test_lock_release();
        int cyc;
        int gate_bad;
        rst_ext  = 1'b0;
        cyc      = 0;
        gate_bad = 0;
        while (pll_locked !== 1'b1 && cyc < 200) begin
            tick(1);
            cyc++;
            if (pll_locked !== 1'b1 && (clk_usb !== 1'b0 || clk_disk !== 1'b0)) gate_bad++;
        end
        n_cmp++;
        if (cyc != 100) begin
            n_err++;
            $display("FAIL lock_latency: got %0d cycles expected %0d", cyc, 100);
        end
        n_cmp++;
        if (gate_bad != 0) begin
            n_err++;
            $display("FAIL clk_gating: got %0d ungated cycles expected %0d", gate_bad, 0);
        end
        cyc = 0;
        while (rst_sys_n !== 1'b1 && cyc < 20) begin
            tick(1);
            cyc++;
        end
        n_cmp++;
        if (cyc != 2) begin
            n_err++;
            $display("FAIL sys_release_latency: got %0d cycles expected %0d", cyc, 2);
        end
        n_cmp++;
        if ({rst_usb_n, rst_disk_n, clk_sys} !== 3'b001) begin
            n_err++;
            $display("FAIL stagger_sys: got %b expected %b", {rst_usb_n, rst_disk_n, clk_sys}, 3'b001);
        end
        tick(1);
        n_cmp++;
        if ({rst_usb_n, rst_disk_n} !== 2'b10) begin
            n_err++;
            $display("FAIL stagger_usb: got %b expected %b", {rst_usb_n, rst_disk_n}, 2'b10);
        end
        tick(1);
        n_cmp++;
        if ({rst_sys_n, rst_usb_n, rst_disk_n, clk_usb, clk_disk} !== 5'b11100) begin
            n_err++;
            $display("FAIL stagger_disk: got %b expected %b", {rst_sys_n, rst_usb_n, rst_disk_n, clk_usb, clk_disk}, 5'b11100);
        end
        tick(2);
        n_cmp++;
        if ({clk_usb, clk_disk} !== 2'b01) begin
            n_err++;
            $display("FAIL clk_div_phase2: got %b expected %b", {clk_usb, clk_disk}, 2'b01);
        end
        tick(1);
        n_cmp++;
        if ({clk_usb, clk_disk} !== 2'b11) begin
            n_err++;
            $display("FAIL clk_div_phase3: got %b expected %b", {clk_usb, clk_disk}, 2'b11);
        end
    endtask

    task automatic test_debug_independence();
        rst_ext = 1'b1;
        tick(1);
        n_cmp++;
        if ({rst_sys_n, rst_usb_n, rst_disk_n, pll_locked, rst_dbg_sync_n} !== 5'b00001) begin
            n_err++;
            $display("FAIL ext_abort: got %b expected %b", {rst_sys_n, rst_usb_n, rst_disk_n, pll_locked, rst_dbg_sync_n}, 5'b00001);
        end
        tick(9);
        n_cmp++;
        if ({rst_sys_n, rst_dbg_sync_n} !== 2'b01) begin
            n_err++;
            $display("FAIL dbg_independent: got %b expected %b", {rst_sys_n, rst_dbg_sync_n}, 2'b01);
        end
        rst_debug_n = 1'b0;
        tick(1);
        n_cmp++;
        if (rst_dbg_sync_n !== 1'b1) begin
            n_err++;
            $display("FAIL dbg_assert_stage1: got %b expected %b", rst_dbg_sync_n, 1'b1);
        end
        tick(1);
        n_cmp++;
        if (rst_dbg_sync_n !== 1'b0) begin
            n_err++;
            $display("FAIL dbg_assert_stage2: got %b expected %b", rst_dbg_sync_n, 1'b0);
        end
        tick(3);
    endtask

    task automatic test_watchdog_expiry();
        rst_ext     = 1'b0;
        rst_debug_n = 1'b1;
        tick(1);
        n_cmp++;
        if (rst_dbg_sync_n !== 1'b0) begin
            n_err++;
            $display("FAIL dbg_release_stage1: got %b expected %b", rst_dbg_sync_n, 1'b0);
        end
        tick(1);
        n_cmp++;
        if (rst_dbg_sync_n !== 1'b1) begin
            n_err++;
            $display("FAIL dbg_release_stage2: got %b expected %b", rst_dbg_sync_n, 1'b1);
        end
        tick(168);
        n_cmp++;
        if ({wdt_reset, rst_sys_n} !== 2'b01) begin
            n_err++;
            $display("FAIL wdt_grace_170: got %b expected %b", {wdt_reset, rst_sys_n}, 2'b01);
        end
        tick(132);
        n_cmp++;
        if (wdt_reset !== 1'b0) begin
            n_err++;
            $display("FAIL wdt_grace_last: got %b expected %b", wdt_reset, 1'b0);
        end
        tick(1);
        n_cmp++;
        if ({wdt_reset, rst_sys_n} !== 2'b11) begin
            n_err++;
            $display("FAIL wdt_expire_edge: got %b expected %b", {wdt_reset, rst_sys_n}, 2'b11);
        end
        tick(1);
        n_cmp++;
        if ({rst_sys_n, rst_usb_n, rst_disk_n, pll_locked} !== 4'b0001) begin
            n_err++;
            $display("FAIL wdt_domain_drop: got %b expected %b", {rst_sys_n, rst_usb_n, rst_disk_n, pll_locked}, 4'b0001);
        end
        wdt_kick = 1'b1;
        tick(1);
        wdt_kick = 1'b0;
        tick(15);
        n_cmp++;
        if ({wdt_reset, rst_sys_n, pll_locked} !== 3'b101) begin
            n_err++;
            $display("FAIL wdt_sticky_320: got %b expected %b", {wdt_reset, rst_sys_n, pll_locked}, 3'b101);
        end
    endtask

    task automatic test_watchdog_kick();
        int hits;
        rst_ext = 1'b1;
        tick(10);
        n_cmp++;
        if ({wdt_reset, rst_sys_n} !== 2'b00) begin
            n_err++;
            $display("FAIL wdt_cleared_by_ext: got %b expected %b", {wdt_reset, rst_sys_n}, 2'b00);
        end
        rst_ext = 1'b0;
        tick(170);
        n_cmp++;
        if ({wdt_reset, rst_sys_n} !== 2'b01) begin
            n_err++;
            $display("FAIL wdt_before_kicks: got %b expected %b", {wdt_reset, rst_sys_n}, 2'b01);
        end
        for (int k = 0; k < 5; k++) begin
            wdt_kick = 1'b1;
            tick(1);
            wdt_kick = 1'b0;
            hits = 0;
            for (int c = 0; c < 50; c++) begin
                tick(1);
                if (wdt_reset !== 1'b0) hits++;
            end
            n_cmp++;
            if (hits != 0) begin
                n_err++;
                $display("FAIL wdt_kick_%0d: got %0d expired cycles expected %0d", k, hits, 0);
            end
        end
        tick(49);
        wdt_kick = 1'b1;
        tick(1);
        wdt_kick = 1'b0;
        n_cmp++;
        if (wdt_reset !== 1'b0) begin
            n_err++;
            $display("FAIL wdt_kick_terminal: got %b expected %b", wdt_reset, 1'b0);
        end
        tick(99);
        n_cmp++;
        if (wdt_reset !== 1'b0) begin
            n_err++;
            $display("FAIL wdt_armed_last: got %b expected %b", wdt_reset, 1'b0);
        end
        tick(1);
        n_cmp++;
        if (wdt_reset !== 1'b1) begin
            n_err++;
            $display("FAIL wdt_armed_expire: got %b expected %b", wdt_reset, 1'b1);
        end
    endtask

    task automatic test_reset_mid_operation();
        rst_ext = 1'b1;
        tick(2);
        rst_ext = 1'b0;
        tick(104);
        n_cmp++;
        if ({rst_sys_n, rst_usb_n, rst_disk_n, pll_locked} !== 4'b1111) begin
            n_err++;
            $display("FAIL midop_running: got %b expected %b", {rst_sys_n, rst_usb_n, rst_disk_n, pll_locked}, 4'b1111);
        end
        rst_ext = 1'b1;
        tick(1);
        n_cmp++;
        if ({rst_sys_n, rst_usb_n, rst_disk_n, pll_locked, clk_usb, clk_disk} !== 6'b000000) begin
            n_err++;
            $display("FAIL midop_abort: got %b expected %b", {rst_sys_n, rst_usb_n, rst_disk_n, pll_locked, clk_usb, clk_disk}, 6'b000000);
        end
        tick(4);
        rst_ext = 1'b0;
        tick(160);
        n_cmp++;
        if ({pll_locked, rst_sys_n, rst_usb_n, rst_disk_n, wdt_reset} !== 5'b11110) begin
            n_err++;
            $display("FAIL midop_relock: got %b expected %b", {pll_locked, rst_sys_n, rst_usb_n, rst_disk_n, wdt_reset}, 5'b11110);
        end
    endtask

    initial begin
        rst_ext     = 1'b1;
        rst_debug_n = 1'b1;
        wdt_kick    = 1'b0;
        test_reset();
        test_lock_release();
        test_debug_independence();
        test_watchdog_expiry();
        test_watchdog_kick();
        test_reset_mid_operation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: got no finish expected finish before 1000000ns");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
